mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared encodings for the instruction/data memory arbiter.
// The arbiter state and grant IDs live here so stall-decoding logic
// elsewhere in the pipeline (e.g. the hazard unit) can decode the same values.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  // True while the arbiter owns the memory port on behalf of a requester.
  function automatic logic arbBusy(arb_state_e s);
    return (s == SERVE_I) || (s == SERVE_D);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, data port and single memory port of
// the arbiter.
//   slave  : arbiter side (mem_arbiter)
//   master : requesters plus memory side (pipeline / memory model / bench)
//
// Handshake: a requester raises x_req with stable operands and keeps them until
// x_done pulses for one cycle. x_stall = x_req & ~x_done. The memory sees
// mem_req with stable mem_addr/mem_we/mem_wdata until it answers with mem_ack,
// and mem_rdata is valid in that same cycle.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              if_stall;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_done;
  logic              dm_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch (I) and
// the data stage (D). One access at a time; ties alternate via lastGrant.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   bus      : mem_arbiter_if.slave (fetch, data and memory ports)
//   dbgState : current arbiter state, for debug/checkers
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus,
  output arb_state_e     dbgState
);

  arb_state_e        state, nextState;
  grant_e            lastGrant;
  logic              grantD;
  logic              anyDone;

  logic              memReq;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic              ifDone, dmDone;
  logic [DATA_W-1:0] ifRdata, dmRdata;

  // No grant in the cycle a done is pulsed: the finished requester is still
  // showing its old req that cycle and must not be re-served by mistake.
  assign anyDone = ifDone | dmDone;

  // Tie-break: D wins if it is the only requester, or on a tie when I was
  // served last.
  always_comb begin
    grantD = 1'b0;
    if (bus.dm_req && (!bus.if_req || lastGrant == GRANT_I))
      grantD = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (!anyDone && (bus.if_req || bus.dm_req))
          nextState = grantD ? SERVE_D : SERVE_I;
      end
      SERVE_I, SERVE_D: begin
        if (bus.mem_ack) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Memory request registers, done pulses and read-data holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memReq    <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= '0;
      memWdata  <= '0;
      ifDone    <= 1'b0;
      dmDone    <= 1'b0;
      ifRdata   <= '0;
      dmRdata   <= '0;
      lastGrant <= GRANT_I;
    end else begin
      ifDone <= 1'b0;
      dmDone <= 1'b0;
      case (state)
        IDLE: begin
          if (nextState == SERVE_I) begin
            memReq  <= 1'b1;
            memWe   <= 1'b0;
            memAddr <= bus.if_addr;
          end else if (nextState == SERVE_D) begin
            memReq   <= 1'b1;
            memWe    <= bus.dm_we;
            memAddr  <= bus.dm_addr;
            memWdata <= bus.dm_wdata;
          end
        end
        SERVE_I: begin
          if (bus.mem_ack) begin
            memReq    <= 1'b0;
            ifDone    <= 1'b1;
            ifRdata   <= bus.mem_rdata;
            lastGrant <= GRANT_I;
          end
        end
        SERVE_D: begin
          if (bus.mem_ack) begin
            memReq    <= 1'b0;
            memWe     <= 1'b0;
            dmDone    <= 1'b1;
            if (!memWe) dmRdata <= bus.mem_rdata;
            lastGrant <= GRANT_D;
          end
        end
        default: memReq <= 1'b0;
      endcase
    end
  end

  assign bus.mem_req   = memReq;
  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign bus.if_done   = ifDone;
  assign bus.dm_done   = dmDone;
  assign bus.if_rdata  = ifRdata;
  assign bus.dm_rdata  = dmRdata;
  assign bus.if_stall  = bus.if_req & ~ifDone;
  assign bus.dm_stall  = bus.dm_req & ~dmDone;
  assign dbgState      = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic       clk;
  logic       rst;
  arb_state_e dbgState;
  int         vectors;
  int         errors;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .dbgState (dbgState)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Observe 2 time units after the rising edge; inputs are changed after that.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    vectors++; if (dbgState !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbgState, IDLE); end
    vectors++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req); end
    vectors++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
    vectors++; if (bus.if_rdata !== 32'h0 || bus.dm_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", bus.if_rdata, bus.dm_rdata); end
    vectors++; if (bus.if_done !== 1'b0 || bus.dm_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b/%b expected 0/0", bus.if_done, bus.dm_done); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_if_only();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    #1;
    vectors++; if (bus.if_stall !== 1'b1) begin errors++; $display("FAIL ifonly_stall_c0: got %b expected 1", bus.if_stall); end
    step();
    vectors++; if (dbgState !== SERVE_I) begin errors++; $display("FAIL ifonly_state_c1: got %0d expected %0d", dbgState, SERVE_I); end
    vectors++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL ifonly_mem_c1: got req=%b addr=%h we=%b expected 1/40/0", bus.mem_req, bus.mem_addr, bus.mem_we); end
    vectors++; if (bus.if_stall !== 1'b1) begin errors++; $display("FAIL ifonly_stall_c1: got %b expected 1", bus.if_stall); end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h8C220004;
    step();
    bus.mem_ack   = 1'b0;
    vectors++; if (bus.if_done !== 1'b1) begin errors++; $display("FAIL ifonly_done_c2: got %b expected 1", bus.if_done); end
    vectors++; if (bus.if_rdata !== 32'h8C220004) begin errors++; $display("FAIL ifonly_rdata: got %h expected 8c220004", bus.if_rdata); end
    vectors++; if (bus.if_stall !== 1'b0) begin errors++; $display("FAIL ifonly_stall_c2: got %b expected 0", bus.if_stall); end
    vectors++; if (dbgState !== IDLE || bus.mem_req !== 1'b0) begin errors++; $display("FAIL ifonly_idle_c2: got state=%0d req=%b expected 0/0", dbgState, bus.mem_req); end
    bus.if_req = 1'b0;
    step();
    vectors++; if (bus.if_done !== 1'b0 || dbgState !== IDLE) begin errors++; $display("FAIL ifonly_c3: got done=%b state=%0d expected 0/0", bus.if_done, dbgState); end
  endtask

  task automatic test_tie_first();
    rst = 1'b1;
    clear_inputs();
    step();
    rst = 1'b0;
    step();
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h44;
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h100;
    bus.dm_wdata = 32'hDEADBEEF;
    step();
    vectors++; if (dbgState !== SERVE_D) begin errors++; $display("FAIL tie_first_grant: got %0d expected %0d", dbgState, SERVE_D); end
    vectors++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL tie_d_mem: got we=%b addr=%h wdata=%h expected 1/100/deadbeef", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h12345678;
    step();
    bus.mem_ack = 1'b0;
    vectors++; if (bus.dm_done !== 1'b1 || bus.if_done !== 1'b0) begin errors++; $display("FAIL tie_d_done: got dm=%b if=%b expected 1/0", bus.dm_done, bus.if_done); end
    vectors++; if (bus.dm_rdata !== 32'h0) begin errors++; $display("FAIL tie_write_rdata: got %h expected 0", bus.dm_rdata); end
    vectors++; if (bus.if_stall !== 1'b1) begin errors++; $display("FAIL tie_if_stall: got %b expected 1", bus.if_stall); end
    bus.dm_req = 1'b0;
    bus.dm_we  = 1'b0;
    step();
    vectors++; if (dbgState !== IDLE) begin errors++; $display("FAIL tie_no_grant_on_done: got %0d expected %0d", dbgState, IDLE); end
    step();
    vectors++; if (dbgState !== SERVE_I || bus.mem_addr !== 32'h44 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL tie_i_second: got state=%0d addr=%h we=%b expected 1/44/0", dbgState, bus.mem_addr, bus.mem_we); end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hA5A5A5A5;
    step();
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    vectors++; if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL tie_i_done: got done=%b rdata=%h expected 1/a5a5a5a5", bus.if_done, bus.if_rdata); end
    vectors++; if (bus.dm_rdata !== 32'h0) begin errors++; $display("FAIL tie_dm_rdata_held: got %h expected 0", bus.dm_rdata); end
    step();
  endtask

  // Last served was I, so with both requesting the order is D, I, D, I, ...
  task automatic test_back_to_back();
    logic       got;
    logic       want_d;
    logic [31:0] want_data;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h80;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h180;
    for (int i = 0; i < 8; i++) begin
      want_d    = (i % 2 == 0);
      want_data = 32'hC0DE0000 + i;
      got = 1'b0;
      for (int w = 0; w < 6 && !got; w++) begin
        step();
        if (dbgState != IDLE) got = 1'b1;
      end
      vectors++; if (got !== 1'b1) begin errors++; $display("FAIL b2b_grant_timeout[%0d]: got none expected grant", i); end
      vectors++; if (dbgState !== (want_d ? SERVE_D : SERVE_I)) begin errors++; $display("FAIL b2b_order[%0d]: got %0d expected %0d", i, dbgState, want_d ? SERVE_D : SERVE_I); end
      step();
      step();
      step();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = want_data;
      step();
      bus.mem_ack = 1'b0;
      if (i == 7) begin
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
      end
      vectors++; if (bus.dm_done !== want_d || bus.if_done !== !want_d) begin errors++; $display("FAIL b2b_done[%0d]: got dm=%b if=%b expected %b/%b", i, bus.dm_done, bus.if_done, want_d, !want_d); end
      vectors++; if ((want_d ? bus.dm_rdata : bus.if_rdata) !== want_data) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", i, want_d ? bus.dm_rdata : bus.if_rdata, want_data); end
      step();
      vectors++; if (bus.dm_done !== 1'b0 || bus.if_done !== 1'b0) begin errors++; $display("FAIL b2b_pulse_width[%0d]: got dm=%b if=%b expected 0/0", i, bus.dm_done, bus.if_done); end
    end
  endtask

  task automatic test_stable_hold();
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h100;
    step();
    vectors++; if (dbgState !== SERVE_D || bus.mem_addr !== 32'h100) begin errors++; $display("FAIL hold_grant: got state=%0d addr=%h expected 2/100", dbgState, bus.mem_addr); end
    bus.dm_addr = 32'h200;
    for (int k = 0; k < 5; k++) begin
      step();
      vectors++; if (bus.mem_addr !== 32'h100 || bus.mem_req !== 1'b1) begin errors++; $display("FAIL hold_addr[%0d]: got addr=%h req=%b expected 100/1", k, bus.mem_addr, bus.mem_req); end
      // Dropping req after the grant must not abort the access.
      if (k == 1) bus.dm_req = 1'b0;
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0BADF00D;
    step();
    bus.mem_ack = 1'b0;
    vectors++; if (bus.dm_done !== 1'b1 || bus.dm_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL hold_done: got done=%b rdata=%h expected 1/0badf00d", bus.dm_done, bus.dm_rdata); end
    step();
    vectors++; if (bus.dm_done !== 1'b0 || dbgState !== IDLE) begin errors++; $display("FAIL hold_after: got done=%b state=%0d expected 0/0", bus.dm_done, dbgState); end
  endtask

  task automatic test_spurious_ack();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFFFFFF;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++; if (bus.if_done !== 1'b0 || bus.dm_done !== 1'b0 || dbgState !== IDLE) begin errors++; $display("FAIL spurious_done[%0d]: got if=%b dm=%b state=%0d expected 0/0/0", k, bus.if_done, bus.dm_done, dbgState); end
      vectors++; if (bus.if_rdata !== 32'hC0DE0007 || bus.dm_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL spurious_rdata[%0d]: got %h/%h expected c0de0007/0badf00d", k, bus.if_rdata, bus.dm_rdata); end
    end
    bus.mem_ack = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h300;
    bus.dm_wdata = 32'h55;
    step();
    vectors++; if (dbgState !== SERVE_D || bus.mem_we !== 1'b1) begin errors++; $display("FAIL rstmid_grant: got state=%0d we=%b expected 2/1", dbgState, bus.mem_we); end
    rst = 1'b1;
    bus.dm_req = 1'b0;
    bus.dm_we  = 1'b0;
    #1;
    vectors++; if (dbgState !== IDLE || bus.mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_async: got state=%0d req=%b expected 0/0", dbgState, bus.mem_req); end
    step();
    rst = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h77;
    step();
    bus.mem_ack = 1'b0;
    vectors++; if (bus.dm_done !== 1'b0 || bus.if_done !== 1'b0 || dbgState !== IDLE) begin errors++; $display("FAIL rstmid_no_done: got dm=%b if=%b state=%0d expected 0/0/0", bus.dm_done, bus.if_done, dbgState); end
    vectors++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rstmid_mem_zero: got %b/%b/%h/%h expected 0/0/0/0", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    vectors++; if (bus.if_rdata !== 32'h0 || bus.dm_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_rdata_zero: got %h/%h expected 0/0", bus.if_rdata, bus.dm_rdata); end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst     = 1'b1;
    clear_inputs();
    test_reset();
    test_if_only();
    test_tie_first();
    test_back_to_back();
    test_stable_hold();
    test_spurious_ack();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
